hall_commutator: RTL and testbench
==================================

HALL_COMMUTATOR -- requirements
Module: hall_commutator

Interface
REQ-001 SHALL have parameter DEADTIME, default 64; all-gates-off cycles inserted before every new drive pattern, legal range 1..65535.
REQ-002 SHALL have parameter FILTER, default 16; consecutive identical synchronised hall samples required before acceptance, legal range 1..255.
REQ-003 SHALL have parameter STALL_TIMEOUT, default 16_000_000; DRIVE cycles without a sector change before stall is flagged.
REQ-004 clk  in  1  system clock (16 MHz domain).
REQ-005 reset_n  in  1  reset, asynchronous and active-low.
REQ-006 enable  in  1  level; 1 permits driving.
REQ-007 dir  in  1  1 = forward table, 0 = reverse table.
REQ-008 pwm_in  in  1  PWM from pwm block; gates high-side switches.
REQ-009 hall  in  3  {h1,h2,h3}, asynchronous.
REQ-010 fault_n  in  1  gate-driver fault, active-low, asynchronous.
REQ-011 clear_fault  in  1  single-cycle request to leave FAULT.
REQ-012 inha, inla, inhb, inlb, inhc, inlc  out  1 each  registered half-bridge gate commands.
REQ-013 sector  out  3  filtered sector 0..5; 7 when hall code invalid.
REQ-014 step_pulse  out  1  one-cycle strobe on each accepted sector change.
REQ-015 step_fwd  out  1  valid with step_pulse; 1 when new sector = (old+1) mod 6.
REQ-016 stalled  out  1  stall flag.  REQ-017 fault_latched  out  1  1 while in FAULT.

Function
REQ-018 hall and fault_n SHALL each pass a 2-flop synchroniser; the filtered hall value SHALL update after FILTER consecutive equal synchronised samples (pin-to-sector latency 2+FILTER cycles).
REQ-019 Decode SHALL be 101->0, 100->1, 110->2, 010->3, 011->4, 001->5; 000 and 111 -> sector 7 (invalid).
REQ-020 step_pulse SHALL fire only for valid-to-valid sector changes; transitions to or from 7 produce no pulse.
REQ-021 FSM states SHALL be IDLE, DEADTIME, DRIVE, FAULT.
REQ-022 IDLE: all gates 0; enable=1, sector valid, synchronised fault_n=1 -> DEADTIME.
REQ-023 DEADTIME: all gates 0; counter loads DEADTIME-1 on entry, decrements each cycle; at 0 -> DRIVE; enable=0 -> IDLE.
REQ-024 DRIVE dir=1 pairs (high,low): s0 C,B; s1 A,B; s2 A,C; s3 B,C; s4 B,A; s5 C,A. dir=0 swaps high and low phase of each pair.
REQ-025 DRIVE: selected high gate <= pwm_in (registered, 1-cycle latency); selected low gate <= 1; other four gates <= 0.
REQ-026 DRIVE: sector change or dir change -> DEADTIME; all gates 0 on the next cycle.
REQ-027 DRIVE: enable=0 -> IDLE; gates 0 on the next cycle.
REQ-028 Any state except FAULT: sector 7 while enable=1, or synchronised fault_n=0, -> FAULT; fault outranks every other transition in the same cycle.
REQ-029 FAULT: gates 0, fault_latched=1; leave to IDLE only when clear_fault=1, fault_n=1 and sector valid in the same cycle; otherwise stay.
REQ-030 inhX and inlX SHALL never both be 1 in any cycle, in any state.
REQ-031 Stall counter SHALL clear on step_pulse and on leaving DRIVE, saturate at STALL_TIMEOUT; stalled=1 while saturated. Stall SHALL NOT stop driving.

Reset
REQ-032 reset_n=0 SHALL force IDLE, all gates 0, sector 7, step_pulse 0, step_fwd 0, stalled 0, fault_latched 0, filter, synchroniser and counters cleared, immediately and independent of clk.
REQ-033 Reset asserted mid-DRIVE SHALL remove gate drive immediately; after release, DEADTIME SHALL be inserted before any gate turns on.

Verification
REQ-034 Reset release, enable=1, dir=1, hall=101, pwm_in=1 -> gates 0 for 2+16+1+64 cycles, then inhc=1, inlb=1, others 0.
REQ-035 DRIVE s1 (dir=1), hall 100->110 -> gates 0 within 1 cycle after filter acceptance, 64 cycles off, then inha=1 (follows pwm_in), inlc=1; step_pulse one cycle, step_fwd=1.
REQ-036 hall glitch 101->100 for 10 cycles then back (FILTER=16) -> sector stays 0, no step_pulse, gates unchanged.
REQ-037 hall=111 in DRIVE -> sector 7, FAULT, gates 0, fault_latched=1; clear_fault with hall=101 -> IDLE, then DEADTIME, then DRIVE.
REQ-038 fault_n pulse low 3 cycles in DRIVE -> FAULT within 3 cycles; clear_fault while fault_n=0 ignored.
REQ-039 STALL_TIMEOUT=100, hold hall in DRIVE -> stalled=1 at cycle 100, gates keep driving; next sector change -> stalled=0.

Source files
------------

// File: rtl/hall_commutator.sv
// Six-step BLDC commutator: synchronised, filtered hall decode driving
// three half-bridges with dead time, fault latching and stall detection.
module hall_commutator #(
    parameter int DEADTIME      = 64,
    parameter int FILTER        = 16,
    parameter int STALL_TIMEOUT = 16_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       dir,
    input  logic       pwm_in,
    input  logic [2:0] hall,
    input  logic       fault_n,
    input  logic       clear_fault,
    output logic       inha,
    output logic       inla,
    output logic       inhb,
    output logic       inlb,
    output logic       inhc,
    output logic       inlc,
    output logic [2:0] sector,
    output logic       step_pulse,
    output logic       step_fwd,
    output logic       stalled,
    output logic       fault_latched
);

    localparam logic [7:0]  FMAX    = 8'(FILTER);
    localparam logic [15:0] DT_LOAD = 16'(DEADTIME - 1);
    localparam logic [31:0] ST_MAX  = 32'(STALL_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEAD,
        S_DRIVE,
        S_FAULT
    } state_t;

    function automatic logic [2:0] decode(input logic [2:0] h);
        case (h)
            3'b101:  decode = 3'd0;
            3'b100:  decode = 3'd1;
            3'b110:  decode = 3'd2;
            3'b010:  decode = 3'd3;
            3'b011:  decode = 3'd4;
            3'b001:  decode = 3'd5;
            default: decode = 3'd7;
        endcase
    endfunction

    logic [2:0]  hs1_q, hs2_q, last_q;
    logic        fs1_q, fs2_q;
    logic [7:0]  fcnt_q, fcnt_d;
    logic [2:0]  sector_q, sector_d, new_sec, sec_inc;
    logic        pulse_q, pulse_d, fwd_q, fwd_d;
    logic        acq_q, accept;

    state_t      state_q;
    logic [15:0] dt_q;
    logic [31:0] stall_q;
    logic [2:0]  gh_q, gl_q;
    logic [2:0]  drv_sec_q;
    logic        drv_dir_q;
    logic [2:0]  hi_oh, lo_oh, pat_h, pat_l;
    logic        fault_now;

    always_comb begin
        new_sec  = decode(hs2_q);
        sec_inc  = (sector_q == 3'd5) ? 3'd0 : sector_q + 3'd1;
        fcnt_d   = 8'd1;
        if (hs2_q == last_q)
            fcnt_d = (fcnt_q == FMAX) ? fcnt_q : fcnt_q + 8'd1;
        accept   = (fcnt_d == FMAX);
        sector_d = accept ? new_sec : sector_q;
        pulse_d  = accept && (new_sec != 3'd7) && (sector_q != 3'd7)
                   && (new_sec != sector_q);
        fwd_d    = pulse_d && (new_sec == sec_inc);
    end

    // Fault synchroniser resets to the inactive level so reset alone
    // does not latch a fault.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs1_q    <= '0;
            hs2_q    <= '0;
            fs1_q    <= 1'b1;
            fs2_q    <= 1'b1;
            last_q   <= '0;
            fcnt_q   <= '0;
            sector_q <= 3'd7;
            pulse_q  <= 1'b0;
            fwd_q    <= 1'b0;
            acq_q    <= 1'b0;
        end else begin
            hs1_q    <= hall;
            hs2_q    <= hs1_q;
            fs1_q    <= fault_n;
            fs2_q    <= fs1_q;
            last_q   <= hs2_q;
            fcnt_q   <= fcnt_d;
            sector_q <= sector_d;
            pulse_q  <= pulse_d;
            fwd_q    <= fwd_d;
            acq_q    <= acq_q | (accept && (new_sec != 3'd7));
        end
    end

    // One-hot phase select, bit order {C,B,A}.
    always_comb begin
        hi_oh = '0;
        lo_oh = '0;
        case (sector_q)
            3'd0: begin hi_oh = 3'b100; lo_oh = 3'b010; end
            3'd1: begin hi_oh = 3'b001; lo_oh = 3'b010; end
            3'd2: begin hi_oh = 3'b001; lo_oh = 3'b100; end
            3'd3: begin hi_oh = 3'b010; lo_oh = 3'b100; end
            3'd4: begin hi_oh = 3'b010; lo_oh = 3'b001; end
            3'd5: begin hi_oh = 3'b100; lo_oh = 3'b001; end
            default: ;
        endcase
        pat_h = (dir ? hi_oh : lo_oh) & {3{pwm_in}};
        pat_l = dir ? lo_oh : hi_oh;
    end

    // An invalid sector only counts once a valid code has been accepted,
    // so the power-up value of 7 does not trip the fault path.
    assign fault_now = !fs2_q || (enable && acq_q && (sector_q == 3'd7));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            dt_q      <= '0;
            stall_q   <= '0;
            gh_q      <= '0;
            gl_q      <= '0;
            drv_sec_q <= 3'd7;
            drv_dir_q <= 1'b0;
        end else begin
            gh_q    <= '0;
            gl_q    <= '0;
            stall_q <= '0;
            unique case (state_q)
                S_IDLE: begin
                    if (fault_now) begin
                        state_q <= S_FAULT;
                    end else if (enable && sector_q != 3'd7) begin
                        state_q <= S_DEAD;
                        dt_q    <= DT_LOAD;
                    end
                end
                S_DEAD: begin
                    if (fault_now) begin
                        state_q <= S_FAULT;
                    end else if (!enable) begin
                        state_q <= S_IDLE;
                    end else if (dt_q == '0) begin
                        state_q   <= S_DRIVE;
                        gh_q      <= pat_h;
                        gl_q      <= pat_l;
                        drv_sec_q <= sector_q;
                        drv_dir_q <= dir;
                    end else begin
                        dt_q <= dt_q - 16'd1;
                    end
                end
                S_DRIVE: begin
                    if (fault_now) begin
                        state_q <= S_FAULT;
                    end else if (!enable) begin
                        state_q <= S_IDLE;
                    end else if (sector_q != drv_sec_q || dir != drv_dir_q) begin
                        state_q <= S_DEAD;
                        dt_q    <= DT_LOAD;
                    end else begin
                        gh_q <= pat_h;
                        gl_q <= pat_l;
                        if (pulse_q)
                            stall_q <= '0;
                        else if (stall_q != ST_MAX)
                            stall_q <= stall_q + 32'd1;
                        else
                            stall_q <= stall_q;
                    end
                end
                S_FAULT: begin
                    if (clear_fault && fs2_q && sector_q != 3'd7)
                        state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign inha          = gh_q[0];
    assign inhb          = gh_q[1];
    assign inhc          = gh_q[2];
    assign inla          = gl_q[0];
    assign inlb          = gl_q[1];
    assign inlc          = gl_q[2];
    assign sector        = sector_q;
    assign step_pulse    = pulse_q;
    assign step_fwd      = fwd_q;
    assign stalled       = (stall_q == ST_MAX);
    assign fault_latched = (state_q == S_FAULT);

endmodule

// File: tb/tb_hall_commutator.sv
// Directed bench for hall_commutator: decode/drive table plus
// timing sequences for dead time, filtering, faults, stall and reset.
module tb_hall_commutator;

    logic       clk = 1'b0;
    logic       reset_n, enable, dir, pwm_in, fault_n, clear_fault;
    logic [2:0] hall;
    logic       inha, inla, inhb, inlb, inhc, inlc;
    logic [2:0] sector;
    logic       step_pulse, step_fwd, stalled, fault_latched;

    int errors = 0;
    int checks = 0;
    int overlap = 0;
    int bad;

    logic [5:0] gates;
    assign gates = {inha, inla, inhb, inlb, inhc, inlc};

    hall_commutator #(
        .DEADTIME(64),
        .FILTER(16),
        .STALL_TIMEOUT(100)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .dir(dir),
        .pwm_in(pwm_in),
        .hall(hall),
        .fault_n(fault_n),
        .clear_fault(clear_fault),
        .inha(inha),
        .inla(inla),
        .inhb(inhb),
        .inlb(inlb),
        .inhc(inhc),
        .inlc(inlc),
        .sector(sector),
        .step_pulse(step_pulse),
        .step_fwd(step_fwd),
        .stalled(stalled),
        .fault_latched(fault_latched)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if ((inha & inla) | (inhb & inlb) | (inhc & inlc))
            overlap++;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0] h;
        logic       d;
        logic       p;
        logic [2:0] sec;
        logic [5:0] g;
    } vec_t;

    vec_t vt[12];

    initial begin
        // gates order {ha,la,hb,lb,hc,lc}
        vt[0]  = '{3'b100, 1'b1, 1'b1, 3'd1, 6'b100100};
        vt[1]  = '{3'b110, 1'b1, 1'b1, 3'd2, 6'b100001};
        vt[2]  = '{3'b010, 1'b1, 1'b0, 3'd3, 6'b000001};
        vt[3]  = '{3'b011, 1'b1, 1'b1, 3'd4, 6'b011000};
        vt[4]  = '{3'b001, 1'b1, 1'b1, 3'd5, 6'b010010};
        vt[5]  = '{3'b001, 1'b0, 1'b1, 3'd5, 6'b100001};
        vt[6]  = '{3'b011, 1'b0, 1'b1, 3'd4, 6'b100100};
        vt[7]  = '{3'b010, 1'b0, 1'b1, 3'd3, 6'b000110};
        vt[8]  = '{3'b110, 1'b0, 1'b1, 3'd2, 6'b010010};
        vt[9]  = '{3'b100, 1'b0, 1'b1, 3'd1, 6'b011000};
        vt[10] = '{3'b101, 1'b0, 1'b1, 3'd0, 6'b001001};
        vt[11] = '{3'b101, 1'b1, 1'b1, 3'd0, 6'b000110};

        reset_n = 1'b0; enable = 1'b1; dir = 1'b1; pwm_in = 1'b1;
        fault_n = 1'b1; clear_fault = 1'b0; hall = 3'b101;
        tick(2);
        chk("rst_gates", 32'(gates), 0);
        chk("rst_sector", 32'(sector), 7);
        chk("rst_pulse", 32'(step_pulse), 0);
        chk("rst_fwd", 32'(step_fwd), 0);
        chk("rst_stalled", 32'(stalled), 0);
        chk("rst_fault", 32'(fault_latched), 0);

        // startup: 2+16+1+64 off cycles then s0 forward
        reset_n = 1'b1;
        bad = 0;
        for (int i = 1; i <= 83; i++) begin
            tick();
            if (i == 17) chk("start_sec_early", 32'(sector), 7);
            if (i == 18) chk("start_sec", 32'(sector), 0);
            if (i < 83 && gates != 6'd0) bad++;
        end
        chk("start_off", 32'(bad), 0);
        chk("start_on", 32'(gates), 32'b000110);

        foreach (vt[k]) begin
            hall = vt[k].h; dir = vt[k].d; pwm_in = vt[k].p;
            tick(100);
            chk($sformatf("vec%0d_sec", k), 32'(sector), 32'(vt[k].sec));
            chk($sformatf("vec%0d_gates", k), 32'(gates), 32'(vt[k].g));
        end
        pwm_in = 1'b1;

        // forward step s1 -> s2
        hall = 3'b100;
        tick(100);
        hall = 3'b110;
        bad = 0;
        for (int i = 1; i <= 84; i++) begin
            tick();
            if (i == 17) chk("fw_pulse_early", 32'(step_pulse), 0);
            if (i == 18) begin
                chk("fw_sector", 32'(sector), 2);
                chk("fw_pulse", 32'(step_pulse), 1);
                chk("fw_fwd", 32'(step_fwd), 1);
                chk("fw_gates_old", 32'(gates), 32'b100100);
            end
            if (i == 19) chk("fw_pulse_end", 32'(step_pulse), 0);
            if (i >= 19 && i <= 82 && gates != 6'd0) bad++;
            if (i == 83) begin
                chk("fw_on", 32'(gates), 32'b100001);
                pwm_in = 1'b0;
            end
            if (i == 84) chk("fw_pwm", 32'(gates), 32'b000001);
        end
        chk("fw_off", 32'(bad), 0);
        pwm_in = 1'b1;

        // reverse step s2 -> s1
        hall = 3'b100;
        tick(18);
        chk("rv_pulse", 32'(step_pulse), 1);
        chk("rv_fwd", 32'(step_fwd), 0);
        tick(82);

        // 10-cycle glitch is rejected
        hall = 3'b101;
        tick(100);
        hall = 3'b100;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) hall = 3'b101;
            tick();
            if (step_pulse || sector != 3'd0 || gates != 6'b000110) bad++;
        end
        chk("glitch", 32'(bad), 0);

        // stall after 100 DRIVE cycles
        hall = 3'b100;
        tick(83);
        chk("stall_drive", 32'(gates), 32'b100100);
        tick(99);
        chk("stall_before", 32'(stalled), 0);
        tick();
        chk("stall_set", 32'(stalled), 1);
        chk("stall_gates", 32'(gates), 32'b100100);
        hall = 3'b110;
        tick(20);
        chk("stall_clear", 32'(stalled), 0);
        tick(80);

        // invalid hall -> FAULT
        hall = 3'b111;
        tick(18);
        chk("inv_sector", 32'(sector), 7);
        tick();
        chk("inv_fault", 32'(fault_latched), 1);
        chk("inv_gates", 32'(gates), 0);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("inv_clr_ignored", 32'(fault_latched), 1);
        hall = 3'b101;
        tick(20);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("inv_cleared", 32'(fault_latched), 0);
        tick(64);
        chk("inv_dead", 32'(gates), 0);
        tick();
        chk("inv_redrive", 32'(gates), 32'b000110);

        // fault_n pulse low for 3 cycles
        fault_n = 1'b0;
        tick(3);
        fault_n = 1'b1;
        chk("fn_fault", 32'(fault_latched), 1);
        chk("fn_gates", 32'(gates), 0);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("fn_clr_ignored", 32'(fault_latched), 1);
        tick(3);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("fn_cleared", 32'(fault_latched), 0);
        tick(65);
        chk("fn_redrive", 32'(gates), 32'b000110);

        // asynchronous reset mid-DRIVE
        tick(100);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_gates", 32'(gates), 0);
        chk("arst_sector", 32'(sector), 7);
        chk("arst_stalled", 32'(stalled), 0);
        tick(2);
        reset_n = 1'b1;
        bad = 0;
        for (int i = 1; i <= 83; i++) begin
            tick();
            if (i < 83 && gates != 6'd0) bad++;
        end
        chk("arst_off", 32'(bad), 0);
        chk("arst_on", 32'(gates), 32'b000110);

        chk("no_overlap", 32'(overlap), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
